ov7670_capture: RTL and testbench

OV7670_CAPTURE -- requirements
Module: ov7670_capture

---
 rtl/ov7670_capture_pkg.sv | 46 ++++
 rtl/ov7670_capture_if.sv | 27 ++
 rtl/ov7670_capture_sync_edge.sv | 35 +++
 rtl/ov7670_capture.sv | 191 +++++++++++++++++++
 tb/tb_ov7670_capture.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ov7670_capture_pkg.sv
// Shared definitions for the OV7670 capture block: FSM encoding, QVGA defaults,
// RGB444 colour-bar constants and the RGB565 -> RGB444 reduction.
package ov7670_capture_pkg;

    typedef enum logic [1:0] {
        S_WAIT_VS = 2'd0,
        S_WAIT_FR = 2'd1,
        S_ACTIVE  = 2'd2
    } cap_state_e;

    localparam int c_qvga_cols    = 320;
    localparam int c_qvga_rows    = 240;
    localparam int c_qvga_nb_pxls = 17;
    localparam int c_rgb444_w     = 12;
    localparam int c_bar_width    = 40;

    localparam logic [11:0] c_bar_white   = 12'hFFF;
    localparam logic [11:0] c_bar_yellow  = 12'hFF0;
    localparam logic [11:0] c_bar_cyan    = 12'h0FF;
    localparam logic [11:0] c_bar_green   = 12'h0F0;
    localparam logic [11:0] c_bar_magenta = 12'hF0F;
    localparam logic [11:0] c_bar_red     = 12'hF00;
    localparam logic [11:0] c_bar_blue    = 12'h00F;
    localparam logic [11:0] c_bar_black   = 12'h000;

    function automatic logic [11:0] bar_color(input logic [2:0] idx);
        logic [11:0] c;
        case (idx)
            3'd0:    c = c_bar_white;
            3'd1:    c = c_bar_yellow;
            3'd2:    c = c_bar_cyan;
            3'd3:    c = c_bar_green;
            3'd4:    c = c_bar_magenta;
            3'd5:    c = c_bar_red;
            3'd6:    c = c_bar_blue;
            default: c = c_bar_black;
        endcase
        return c;
    endfunction

    // byte0 = {R[4:0],G[5:3]}, byte1 = {G[2:0],B[4:0]}; keep the top 4 bits of each.
    function automatic logic [11:0] rgb565_to_444(input logic [7:0] b0, input logic [7:0] b1);
        return {b0[7:4], b0[2:0], b1[7], b1[4:1]};
    endfunction

endpackage

// File: rtl/ov7670_capture_if.sv
// Camera byte bus plus frame-buffer write port of the capture block.
// master = sensor/consumer side, slave = capture side.
interface ov7670_capture_if #(
    parameter int c_nb_img_pxls = 17,
    parameter int c_nb_buf      = 12
);
    logic                     cam_pclk;
    logic                     cam_vsync;
    logic                     cam_href;
    logic [7:0]               cam_data;
    logic                     wea;
    logic [c_nb_img_pxls-1:0] addra;
    logic [c_nb_buf-1:0]      dina;
    logic                     frame_done;
    logic                     overflow;

    // wea is a one-cycle strobe with no back-pressure: addra/dina are valid
    // exactly in the cycle wea is high and the buffer must accept them.
    modport master (
        output cam_pclk, cam_vsync, cam_href, cam_data,
        input  wea, addra, dina, frame_done, overflow
    );
    modport slave (
        input  cam_pclk, cam_vsync, cam_href, cam_data,
        output wea, addra, dina, frame_done, overflow
    );
endinterface

// File: rtl/ov7670_capture_sync_edge.sv
// Two-flop synchronizer with rise/fall detection on the synchronized level.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign dout = sync_q;
    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;
endmodule

// File: rtl/ov7670_capture.sv
// OV7670 RGB565 capture into an RGB444 frame buffer, oversampling the camera bus on clk.
// Optional macro CAPTURE_TESTPAT_EN replaces camera pixels with column colour bars.
module ov7670_capture
    import ov7670_capture_pkg::*;
#(
    parameter int c_img_cols    = c_qvga_cols,
    parameter int c_img_rows    = c_qvga_rows,
    parameter int c_nb_img_pxls = c_qvga_nb_pxls,
    parameter int c_nb_buf      = c_rgb444_w
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cam_pclk,
    input  logic                     cam_vsync,
    input  logic                     cam_href,
    input  logic [7:0]               cam_data,
    output logic                     wea,
    output logic [c_nb_img_pxls-1:0] addra,
    output logic [c_nb_buf-1:0]      dina,
    output logic                     frame_done,
    output logic                     overflow,
    output cap_state_e               state_dbg
);
    localparam int c_img_pxls = c_img_cols * c_img_rows;
    localparam logic [c_nb_img_pxls-1:0] c_pxl_limit = c_nb_img_pxls'(c_img_pxls);

    logic pclk_rise, vsync_s, vsync_rise, href_s, href_fall;
    logic unused_pclk_level, unused_pclk_fall, unused_vsync_fall, unused_href_rise;

    sync_edge u_sync_pclk (
        .clk(clk), .rst(rst), .din(cam_pclk),
        .dout(unused_pclk_level), .rise(pclk_rise), .fall(unused_pclk_fall)
    );
    sync_edge u_sync_vsync (
        .clk(clk), .rst(rst), .din(cam_vsync),
        .dout(vsync_s), .rise(vsync_rise), .fall(unused_vsync_fall)
    );
    sync_edge u_sync_href (
        .clk(clk), .rst(rst), .din(cam_href),
        .dout(href_s), .rise(unused_href_rise), .fall(href_fall)
    );

    // Same two-stage depth as the control lines so data lines up with the pclk event.
    logic [7:0] data_meta_q, data_meta_d, data_sync_q, data_sync_d;

    cap_state_e               state_q, state_d;
    logic                     phase_q, phase_d;
    logic [7:0]               byte0_q, byte0_d;
    logic [c_nb_img_pxls-1:0] cnt_q, cnt_d;
    logic                     wea_q, wea_d;
    logic [c_nb_img_pxls-1:0] addra_q, addra_d;
    logic [c_nb_buf-1:0]      dina_q, dina_d;
    logic                     frame_done_q, frame_done_d;
    logic                     overflow_q, overflow_d;
    logic [c_nb_buf-1:0]      pix_word;

`ifdef CAPTURE_TESTPAT_EN
    localparam int c_col_w = $clog2(c_img_cols + 1);
    logic [c_col_w-1:0] col_q, col_d;
    logic [5:0]         bar_pos_q, bar_pos_d;
    logic [2:0]         bar_idx_q, bar_idx_d;
    logic               line_clr;
    logic [15:0]        unused_cam_word;

    assign unused_cam_word = {byte0_q, data_sync_q};
    assign line_clr = href_fall || (state_q == S_WAIT_FR && !vsync_s);

    // Column tracking advances only on real writes so bars match addra timing.
    always_comb begin
        col_d     = col_q;
        bar_pos_d = bar_pos_q;
        bar_idx_d = bar_idx_q;
        if (line_clr || (wea_d && col_q == c_col_w'(c_img_cols - 1))) begin
            col_d     = '0;
            bar_pos_d = '0;
            bar_idx_d = '0;
        end else if (wea_d) begin
            col_d = col_q + 1'b1;
            if (bar_pos_q == 6'(c_bar_width - 1)) begin
                bar_pos_d = '0;
                if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 1'b1;
            end else begin
                bar_pos_d = bar_pos_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q     <= '0;
            bar_pos_q <= '0;
            bar_idx_q <= '0;
        end else begin
            col_q     <= col_d;
            bar_pos_q <= bar_pos_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    assign pix_word = c_nb_buf'(bar_color(bar_idx_q));
`else
    assign pix_word = c_nb_buf'(rgb565_to_444(byte0_q, data_sync_q));
`endif

    always_comb begin
        data_meta_d  = cam_data;
        data_sync_d  = data_meta_q;
        state_d      = state_q;
        phase_d      = phase_q;
        byte0_d      = byte0_q;
        cnt_d        = cnt_q;
        wea_d        = 1'b0;
        addra_d      = addra_q;
        dina_d       = dina_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        case (state_q)
            S_WAIT_VS: begin
                phase_d = 1'b0;
                if (vsync_s) state_d = S_WAIT_FR;
            end
            S_WAIT_FR: begin
                phase_d = 1'b0;
                if (!vsync_s) begin
                    state_d = S_ACTIVE;
                    cnt_d   = '0;
                end
            end
            S_ACTIVE: begin
                if (vsync_rise) begin
                    frame_done_d = 1'b1;
                    phase_d      = 1'b0;
                    state_d      = S_WAIT_FR;
                end else if (pclk_rise && href_s) begin
                    if (!phase_q) begin
                        byte0_d = data_sync_q;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (cnt_q != c_pxl_limit) begin
                            wea_d   = 1'b1;
                            addra_d = cnt_q;
                            dina_d  = pix_word;
                            cnt_d   = cnt_q + 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end else if ((pclk_rise && !href_s) || href_fall) begin
                    phase_d = 1'b0;
                end
            end
            default: state_d = S_WAIT_VS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_meta_q  <= '0;
            data_sync_q  <= '0;
            state_q      <= S_WAIT_VS;
            phase_q      <= 1'b0;
            byte0_q      <= '0;
            cnt_q        <= '0;
            wea_q        <= 1'b0;
            addra_q      <= '0;
            dina_q       <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            data_meta_q  <= data_meta_d;
            data_sync_q  <= data_sync_d;
            state_q      <= state_d;
            phase_q      <= phase_d;
            byte0_q      <= byte0_d;
            cnt_q        <= cnt_d;
            wea_q        <= wea_d;
            addra_q      <= addra_d;
            dina_q       <= dina_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign wea        = wea_q;
    assign addra      = addra_q;
    assign dina       = dina_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign state_dbg  = state_q;
endmodule

// File: tb/tb_ov7670_capture.sv
// Scoreboard bench for ov7670_capture: a sensor driver pushes expected writes,
// a monitor pops them on every wea. Frame shortened to 320x4 to bound run time.
module tb_ov7670_capture;
    import ov7670_capture_pkg::*;

    localparam int COLS  = 320;
    localparam int ROWS  = 4;
    localparam int TOTAL = COLS * ROWS;
    localparam int AW    = 17;
    localparam int DW    = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    cap_state_e state_dbg;

    ov7670_capture_if #(.c_nb_img_pxls(AW), .c_nb_buf(DW)) bus ();

    ov7670_capture #(
        .c_img_cols(COLS), .c_img_rows(ROWS), .c_nb_img_pxls(AW), .c_nb_buf(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .cam_pclk(bus.cam_pclk), .cam_vsync(bus.cam_vsync),
        .cam_href(bus.cam_href), .cam_data(bus.cam_data),
        .wea(bus.wea), .addra(bus.addra), .dina(bus.dina),
        .frame_done(bus.frame_done), .overflow(bus.overflow),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // reference model state
    logic [AW+DW-1:0] exp_q[$];
    bit  m_active = 0;
    bit  m_ovf    = 0;
    int  m_idx    = 0;
    int  m_col    = 0;
    int  m_fd     = 0;
    int  m_writes = 0;
    logic [11:0] bar_tab[8];

    // monitor observations
    int  n_writes  = 0;
    int  fd_seen   = 0;
    bit  fd_prev   = 0;
    int  last_addr = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [AW+DW-1:0] e;
        if (bus.wea) begin
            n_writes++;
            last_addr = int'(bus.addra);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write addr=%0d data=%h", bus.addra, bus.dina);
            end else begin
                e = exp_q.pop_front();
                if ({bus.addra, bus.dina} !== e) begin
                    bad++;
                    $display("FAIL write actual addr=%0d data=%h expected addr=%0d data=%h",
                             bus.addra, bus.dina, e[AW+DW-1:DW], e[DW-1:0]);
                end
            end
        end
        if (bus.frame_done) begin
            fd_seen++;
            total++;
            if (fd_prev) begin
                bad++;
                $display("FAIL frame_done_width actual=2+ cycles expected=1 cycle");
            end
        end
        fd_prev = bus.frame_done;
    end

    // driver tasks
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.cam_data = b;
        bus.cam_pclk = 1'b0;
        repeat (2) @(negedge clk);
        bus.cam_pclk = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_pixel(input logic [4:0] r, input logic [5:0] g, input logic [4:0] b);
        logic [11:0] color;
        logic [7:0] b0, b1;
`ifdef CAPTURE_TESTPAT_EN
        color = bar_tab[m_col / 40];
`else
        color = {4'(r / 2), 4'(g / 4), 4'(b / 2)};
`endif
        if (m_active) begin
            if (m_idx < TOTAL) begin
                exp_q.push_back({AW'(m_idx), color});
                m_idx++;
                m_col++;
                m_writes++;
            end else begin
                m_ovf = 1'b1;
            end
        end
        b0 = {r, g[5:3]};
        b1 = {g[2:0], b};
        send_byte(b0);
        send_byte(b1);
    endtask

    // mode 0 random pixels, 1 red, 2 alternating green/blue; odd adds a trailing byte
    task automatic send_line(input int n_px, input int mode, input bit odd);
        logic [4:0] r, bl;
        logic [5:0] g;
        @(negedge clk);
        bus.cam_href = 1'b1;
        m_col = 0;
        for (int i = 0; i < n_px; i++) begin
            case (mode)
                1: begin r = 5'd31; g = 6'd0; bl = 5'd0; end
                2: begin
                    if (i % 2 == 0) begin r = 5'd0; g = 6'd63; bl = 5'd0; end
                    else            begin r = 5'd0; g = 6'd0;  bl = 5'd31; end
                end
                default: begin
                    r  = 5'($urandom_range(0, 31));
                    g  = 6'($urandom_range(0, 63));
                    bl = 5'($urandom_range(0, 31));
                end
            endcase
            send_pixel(r, g, bl);
        end
        if (odd) send_byte(8'($urandom_range(0, 255)));
        @(negedge clk);
        bus.cam_pclk = 1'b0;
        bus.cam_href = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic vsync_pulse();
        @(negedge clk);
        bus.cam_vsync = 1'b1;
        if (m_active) m_fd++;
        repeat (12) @(negedge clk);
        bus.cam_vsync = 1'b0;
        m_active = 1'b1;
        m_idx = 0;
        repeat (12) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_active = 1'b0;
        m_ovf = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_wea"}, 32'(bus.wea), 32'd0);
        check({tag, "_addra"}, 32'(bus.addra), 32'd0);
        check({tag, "_dina"}, 32'(bus.dina), 32'd0);
        check({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
        check({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'(S_WAIT_VS));
    endtask

    task automatic drain();
        repeat (20) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bar_tab[0] = 12'hFFF; bar_tab[1] = 12'hFF0; bar_tab[2] = 12'h0FF; bar_tab[3] = 12'h0F0;
        bar_tab[4] = 12'hF0F; bar_tab[5] = 12'hF00; bar_tab[6] = 12'h00F; bar_tab[7] = 12'h000;
        bus.cam_pclk = 1'b0; bus.cam_vsync = 1'b0; bus.cam_href = 1'b0; bus.cam_data = 8'h00;

        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

        // pixels before any vsync must be ignored
        send_line(3, 0, 1'b0);
        drain();

        // one red line, then green/blue pairs
        vsync_pulse();
        check("state_active", 32'(state_dbg), 32'(S_ACTIVE));
        send_line(COLS, 1, 1'b0);
        drain();
        check("line_writes", 32'(n_writes), 32'(COLS));
        check("line_last_addr", 32'(last_addr), 32'(COLS - 1));
        send_line(6, 2, 1'b0);

        // odd trailing byte dropped, next line realigned
        send_line(1, 0, 1'b1);
        send_line(4, 0, 1'b0);
        drain();

        // random frame
        vsync_pulse();
        for (int l = 0; l < 4; l++) send_line($urandom_range(1, 40), 0, 1'($urandom_range(0, 1)));
        drain();
        check("fd_count_random", 32'(fd_seen), 32'(m_fd));

        // full frame plus 5 extra pixels
        vsync_pulse();
        for (int l = 0; l < ROWS; l++) send_line(COLS, 0, 1'b0);
        drain();
        check("full_last_addr", 32'(last_addr), 32'(TOTAL - 1));
        check("full_overflow_clear", 32'(bus.overflow), 32'(m_ovf));
        send_line(5, 0, 1'b0);
        drain();
        check("overflow_set", 32'(bus.overflow), 32'(m_ovf));
        check("overflow_expected", 32'(m_ovf), 32'd1);
        vsync_pulse();
        check("fd_count_full", 32'(fd_seen), 32'(m_fd));
        check("overflow_sticky", 32'(bus.overflow), 32'd1);
        send_line(5, 0, 1'b0);
        drain();

        // reset at pixel 1000 aborts the frame
        vsync_pulse();
        for (int l = 0; l < 3; l++) send_line(COLS, 0, 1'b0);
        send_line(1000 - 3 * COLS, 0, 1'b0);
        drain();
        check("pre_rst_last_addr", 32'(last_addr), 32'd999);
        do_reset();
        check_reset_state("midframe_rst");
        send_line(20, 0, 1'b0);
        drain();
        vsync_pulse();
        send_line(10, 0, 1'b0);
        drain();
        check("restart_last_addr", 32'(last_addr), 32'd9);
        check("fd_count_final", 32'(fd_seen), 32'(m_fd));
        check("write_count", 32'(n_writes), 32'(m_writes));
        check("overflow_after_rst", 32'(bus.overflow), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
